// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the decode / ID-EX slice: opcode map, instruction field
// positions and operand source selects.
package id_ex_stage_pkg;

   localparam int unsigned DSIZE_SHARED = 16;
   localparam int unsigned RSIZE_SHARED = 4;

   // Instruction layout: [15:12] op, [11:8] rd/rt2, [7:4] rs, [3:0] rt/imm4
   localparam int unsigned OP_HI  = 15;
   localparam int unsigned OP_LO  = 12;
   localparam int unsigned RD_HI  = 11;
   localparam int unsigned RD_LO  = 8;
   localparam int unsigned RS_HI  = 7;
   localparam int unsigned RS_LO  = 4;
   localparam int unsigned RT_HI  = 3;
   localparam int unsigned RT_LO  = 0;

   // Opcodes 10..15 are illegal and issue as bubbles.
   typedef enum logic [3:0] {
      OpAdd  = 4'd0,
      OpSub  = 4'd1,
      OpAnd  = 4'd2,
      OpXor  = 4'd3,
      OpCom  = 4'd4,
      OpMul  = 4'd5,
      OpAddi = 4'd6,
      OpLw   = 4'd7,
      OpSw   = 4'd8,
      OpBeq  = 4'd9
   } op_e;

   typedef enum logic [1:0] {
      SrcRf  = 2'd0,
      SrcWb  = 2'd1,
      SrcMem = 2'd2
   } src_sel_e;

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Combinational RAW hazard detection and operand source selection.
// FWD_EN: forward non-load MEM results and stall only on EX or load-use hits.
module id_ex_stage_hazard_unit
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned RSIZE = RSIZE_SHARED
) (
   input  logic [RSIZE-1:0] src1,
   input  logic [RSIZE-1:0] src2,
   input  logic             use1,
   input  logic             use2,
   input  logic [RSIZE-1:0] ex_rd,
   input  logic             ex_wen,
   input  logic [RSIZE-1:0] mem_rd,
   input  logic             mem_wen,
   input  logic             mem_memread,
   input  logic [RSIZE-1:0] wb_rd,
   input  logic             wb_wen,
   output logic             hazard,
   output src_sel_e         sel1,
   output src_sel_e         sel2
);

   function automatic logic hit(input logic [RSIZE-1:0] s, input logic u,
                                input logic [RSIZE-1:0] d, input logic w);
      return u && (s != '0) && w && (s == d);
   endfunction

   logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;

   assign ex_hit1  = hit(src1, use1, ex_rd, ex_wen);
   assign ex_hit2  = hit(src2, use2, ex_rd, ex_wen);
   assign mem_hit1 = hit(src1, use1, mem_rd, mem_wen);
   assign mem_hit2 = hit(src2, use2, mem_rd, mem_wen);
   assign wb_hit1  = hit(src1, use1, wb_rd, wb_wen);
   assign wb_hit2  = hit(src2, use2, wb_rd, wb_wen);

`ifdef FWD_EN
   assign hazard = ex_hit1 | ex_hit2 | ((mem_hit1 | mem_hit2) & mem_memread);

   // MEM result is younger than WB, so it wins when both match.
   always_comb begin
      sel1 = SrcRf;
      sel2 = SrcRf;
      if (mem_hit1 && !mem_memread) sel1 = SrcMem;
      else if (wb_hit1)             sel1 = SrcWb;
      if (mem_hit2 && !mem_memread) sel2 = SrcMem;
      else if (wb_hit2)             sel2 = SrcWb;
   end
`else
   logic unused_mem_memread;
   assign unused_mem_memread = mem_memread;

   assign hazard = ex_hit1 | ex_hit2 | mem_hit1 | mem_hit2;

   always_comb begin
      sel1 = SrcRf;
      sel2 = SrcRf;
      if (wb_hit1) sel1 = SrcWb;
      if (wb_hit2) sel2 = SrcWb;
   end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register: decode, WB bypass, RAW stall/bubble.
// Optional MEM-stage forwarding is enabled with the FWD_EN macro (see hazard unit).
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned DSIZE = DSIZE_SHARED,
   parameter int unsigned RSIZE = RSIZE_SHARED,
   parameter int unsigned CSIZE = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid,
   input  logic [15:0]      if_instr,
   input  logic             flush,
   output logic             stall_out,
   output logic [RSIZE-1:0] rf_raddr1,
   output logic [RSIZE-1:0] rf_raddr2,
   input  logic [DSIZE-1:0] rf_rdata1,
   input  logic [DSIZE-1:0] rf_rdata2,
   input  logic [RSIZE-1:0] mem_rd,
   input  logic             mem_wen,
   input  logic             mem_memread,
   input  logic [DSIZE-1:0] mem_result,
   input  logic [RSIZE-1:0] wb_rd,
   input  logic             wb_wen,
   input  logic [DSIZE-1:0] wb_data,
   output logic             ex_valid,
   output logic [3:0]       ex_op,
   output logic [DSIZE-1:0] ex_a,
   output logic [DSIZE-1:0] ex_b,
   output logic [DSIZE-1:0] ex_store_data,
   output logic [DSIZE-1:0] ex_br_off,
   output logic [RSIZE-1:0] ex_rd,
   output logic             ex_wen,
   output logic             ex_memread,
   output logic             ex_memwrite,
   output logic             ex_branch,
   output logic [CSIZE-1:0] stall_cnt
);

   logic [3:0]       op;
   logic [RSIZE-1:0] f_rd, f_rs, f_rt;
   logic [3:0]       f_imm;
   logic [DSIZE-1:0] imm_sext;

   assign op       = if_instr[OP_HI:OP_LO];
   assign f_rd     = RSIZE'(if_instr[RD_HI:RD_LO]);
   assign f_rs     = RSIZE'(if_instr[RS_HI:RS_LO]);
   assign f_rt     = RSIZE'(if_instr[RT_HI:RT_LO]);
   assign f_imm    = if_instr[RT_HI:RT_LO];
   assign imm_sext = {{(DSIZE-4){f_imm[3]}}, f_imm};

   logic is_rtype, is_imm, is_lw, is_sw, is_beq, legal;

   always_comb begin
      is_rtype = 1'b0;
      is_imm   = 1'b0;
      is_lw    = 1'b0;
      is_sw    = 1'b0;
      is_beq   = 1'b0;
      case (op)
         OpAdd, OpSub, OpAnd, OpXor, OpCom, OpMul: is_rtype = 1'b1;
         OpAddi: is_imm = 1'b1;
         OpLw: begin
            is_imm = 1'b1;
            is_lw  = 1'b1;
         end
         OpSw:    is_sw  = 1'b1;
         OpBeq:   is_beq = 1'b1;
         default: ;
      endcase
   end

   assign legal = is_rtype | is_imm | is_sw | is_beq;

   // Port A always feeds operand a; port B feeds operand b or store data.
   logic [RSIZE-1:0] src1, src2;
   logic             use1, use2, use2_raw;

   always_comb begin
      src1     = f_rs;
      src2     = '0;
      use2_raw = 1'b0;
      if (is_beq) begin
         src1     = f_rd;
         src2     = f_rs;
         use2_raw = 1'b1;
      end else if (is_rtype) begin
         src2     = f_rt;
         use2_raw = 1'b1;
      end else if (is_sw) begin
         src2     = f_rd;
         use2_raw = 1'b1;
      end
   end

   assign use1      = if_valid & legal;
   assign use2      = use1 & use2_raw;
   assign rf_raddr1 = src1;
   assign rf_raddr2 = src2;

   logic     hazard;
   src_sel_e sel1, sel2;

   logic [RSIZE-1:0] ex_rd_q;
   logic             ex_valid_q, ex_wen_q;

   id_ex_stage_hazard_unit #(
      .RSIZE(RSIZE)
   ) hazard_unit (
      .src1       (src1),
      .src2       (src2),
      .use1       (use1),
      .use2       (use2),
      .ex_rd      (ex_rd_q),
      .ex_wen     (ex_wen_q & ex_valid_q),
      .mem_rd     (mem_rd),
      .mem_wen    (mem_wen),
      .mem_memread(mem_memread),
      .wb_rd      (wb_rd),
      .wb_wen     (wb_wen),
      .hazard     (hazard),
      .sel1       (sel1),
      .sel2       (sel2)
   );

   logic [DSIZE-1:0] val1, val2;

   always_comb begin
      val1 = rf_rdata1;
      case (sel1)
         SrcWb:   val1 = wb_data;
         SrcMem:  val1 = mem_result;
         default: ;
      endcase
      if (src1 == '0) val1 = '0;
      val2 = rf_rdata2;
      case (sel2)
         SrcWb:   val2 = wb_data;
         SrcMem:  val2 = mem_result;
         default: ;
      endcase
      if (src2 == '0) val2 = '0;
   end

   logic issue;

   // Flush overrides the stall so a killed instruction never counts as stalled.
   assign stall_out = use1 & hazard & ~flush;
   assign issue     = use1 & ~hazard & ~flush;

   logic [3:0]       ex_op_q, ex_op_d;
   logic [DSIZE-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
   logic [DSIZE-1:0] ex_store_data_q, ex_store_data_d, ex_br_off_q, ex_br_off_d;
   logic [RSIZE-1:0] ex_rd_d;
   logic             ex_valid_d, ex_wen_d;
   logic             ex_memread_q, ex_memread_d, ex_memwrite_q, ex_memwrite_d;
   logic             ex_branch_q, ex_branch_d;
   logic [CSIZE-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      ex_valid_d      = 1'b0;
      ex_op_d         = '0;
      ex_a_d          = '0;
      ex_b_d          = '0;
      ex_store_data_d = '0;
      ex_br_off_d     = '0;
      ex_rd_d         = '0;
      ex_wen_d        = 1'b0;
      ex_memread_d    = 1'b0;
      ex_memwrite_d   = 1'b0;
      ex_branch_d     = 1'b0;
      if (issue) begin
         ex_valid_d      = 1'b1;
         ex_op_d         = op;
         ex_a_d          = val1;
         ex_b_d          = (is_rtype | is_beq) ? val2 : imm_sext;
         ex_store_data_d = is_sw ? val2 : '0;
         ex_br_off_d     = is_beq ? imm_sext : '0;
         ex_rd_d         = (is_rtype | is_imm) ? f_rd : '0;
         ex_wen_d        = (is_rtype | is_imm) & (f_rd != '0);
         ex_memread_d    = is_lw;
         ex_memwrite_d   = is_sw;
         ex_branch_d     = is_beq;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_out && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CSIZE'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q      <= 1'b0;
         ex_op_q         <= '0;
         ex_a_q          <= '0;
         ex_b_q          <= '0;
         ex_store_data_q <= '0;
         ex_br_off_q     <= '0;
         ex_rd_q         <= '0;
         ex_wen_q        <= 1'b0;
         ex_memread_q    <= 1'b0;
         ex_memwrite_q   <= 1'b0;
         ex_branch_q     <= 1'b0;
         stall_cnt_q     <= '0;
      end else begin
         ex_valid_q      <= ex_valid_d;
         ex_op_q         <= ex_op_d;
         ex_a_q          <= ex_a_d;
         ex_b_q          <= ex_b_d;
         ex_store_data_q <= ex_store_data_d;
         ex_br_off_q     <= ex_br_off_d;
         ex_rd_q         <= ex_rd_d;
         ex_wen_q        <= ex_wen_d;
         ex_memread_q    <= ex_memread_d;
         ex_memwrite_q   <= ex_memwrite_d;
         ex_branch_q     <= ex_branch_d;
         stall_cnt_q     <= stall_cnt_d;
      end
   end

   assign ex_valid      = ex_valid_q;
   assign ex_op         = ex_op_q;
   assign ex_a          = ex_a_q;
   assign ex_b          = ex_b_q;
   assign ex_store_data = ex_store_data_q;
   assign ex_br_off     = ex_br_off_q;
   assign ex_rd         = ex_rd_q;
   assign ex_wen        = ex_wen_q;
   assign ex_memread    = ex_memread_q;
   assign ex_memwrite   = ex_memwrite_q;
   assign ex_branch     = ex_branch_q;
   assign stall_cnt     = stall_cnt_q;

endmodule
